// File: rtl/rocev2_dldu_pkg.sv
// Shared definitions for the HLS dataflow deadlock confirm unit.
//   - dldu_state_e : confirm FSM state encodings (2 bits)
//   - dldu_cnt_w   : width of a counter that must hold 0..stable_cycles
package rocev2_dldu_pkg;

    typedef enum logic [1:0] {
        DLDU_IDLE     = 2'd0,
        DLDU_ARMED    = 2'd1,
        DLDU_REPORTED = 2'd2
    } dldu_state_e;

    // Confirm counter width: enough bits to reach stable_cycles itself.
    function automatic int dldu_cnt_w(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/rocev2_dldu_dep_merge.sv
// Masked OR-reduction of the input dependence bitmaps.
// Ports:
//   vld_i  [IN_CHAN_NUM]           : valid flag per input channel
//   data_i [IN_CHAN_NUM*PROC_NUM]  : bitmap per channel, channel i at [i*PROC_NUM +: PROC_NUM]
//   dep_o  [PROC_NUM]              : OR of the bitmaps whose channel is valid
module rocev2_dldu_dep_merge #(
    parameter int PROC_NUM    = 4,
    parameter int IN_CHAN_NUM = 2
) (
    input  logic [IN_CHAN_NUM-1:0]          vld_i,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data_i,
    output logic [PROC_NUM-1:0]             dep_o
);

    // OR together every valid channel bitmap; invalid channels contribute nothing.
    always_comb begin
        dep_o = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            if (vld_i[i]) begin
                dep_o = dep_o | data_i[i*PROC_NUM +: PROC_NUM];
            end else begin
                dep_o = dep_o;
            end
        end
    end

endmodule

// File: rtl/rocev2_top_hls_deadlock_confirm_unit.sv
// Per-process deadlock detection node with multi-cycle confirmation.
// Merges the input dependence bitmaps, forwards this process's dependence
// downstream, and reports a deadlock only once the self-dependence loop has
// been observed unchanged for STABLE_CYCLES consecutive evaluated cycles.
// Optional feature macro: DLDU_STALL_CNT_EN adds the saturating stall_cnt output.
// Ports:
//   clock, reset (async, active-low)
//   proc_dep_vld_vec / out_chan_dep_vld_vec : blocked-per-output-channel, passed through
//   in_chan_dep_vld_vec / in_chan_dep_data_vec : input dependence channels
//   token_in_vec / token_out_vec / origin / token_clear : report-token ring
//   dl_detect_in : global deadlock already detected (freezes dependence unless a token arrives)
//   out_chan_dep_data : registered dependence with own bit set
//   dl_detect_out : one-cycle confirmation pulse; dl_cycle_procs : latched loop set
//   dl_active : FSM in REPORTED; stall_cnt : consecutive blocked cycles (macro only)
module rocev2_top_hls_deadlock_confirm_unit
    import rocev2_dldu_pkg::*;
#(
    parameter int PROC_NUM      = 4,
    parameter int PROC_ID       = 0,
    parameter int IN_CHAN_NUM   = 2,
    parameter int OUT_CHAN_NUM  = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [PROC_NUM-1:0]             dl_cycle_procs,
    output logic                            dl_active
`ifdef DLDU_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]          stall_cnt
`endif
);

    localparam int                  CNT_W    = dldu_cnt_w(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    // cnt_q == CNT_LAST is the same test as cnt_q + 1 == STABLE_CYCLES without overflow.
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

    dldu_state_e                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PROC_NUM-1:0]        snap_q, snap_d;
    logic [PROC_NUM-1:0]        procs_q, procs_d;
    logic                       pulse_q, pulse_d;
    logic [PROC_NUM-1:0]        dep_reg_q;
    logic [OUT_CHAN_NUM-1:0]    token_q;

    logic [PROC_NUM-1:0]        dep_comb_s;
    logic [PROC_NUM-1:0]        dep_next_s;
    logic                       sel_s;
    logic                       blocked_s;
    logic                       hit_s;

    rocev2_dldu_dep_merge #(
        .PROC_NUM    (PROC_NUM),
        .IN_CHAN_NUM (IN_CHAN_NUM)
    ) u_dep_merge (
        .vld_i  (in_chan_dep_vld_vec),
        .data_i (in_chan_dep_data_vec),
        .dep_o  (dep_comb_s)
    );

    // Once a deadlock is known globally, dependence is frozen unless a token is passing through.
    assign sel_s      = ~dl_detect_in | (|token_in_vec);
    assign dep_next_s = sel_s ? dep_comb_s : dep_reg_q;
    assign blocked_s  = |proc_dep_vld_vec;
    assign hit_s      = sel_s & blocked_s & dep_next_s[PROC_ID];

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg_q | SELF_BIT;
    assign token_out_vec        = token_q;
    assign dl_detect_out        = pulse_q;
    assign dl_cycle_procs       = procs_q;
    assign dl_active            = (state_q == DLDU_REPORTED);

    // Confirm FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= DLDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Confirm FSM next-state decode; ARMED rules are priority ordered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DLDU_IDLE: begin
                if (hit_s) begin
                    state_d = (STABLE_CYCLES == 1) ? DLDU_REPORTED : DLDU_ARMED;
                end else begin
                    state_d = DLDU_IDLE;
                end
            end
            DLDU_ARMED: begin
                if (!blocked_s) begin
                    state_d = DLDU_IDLE;
                end else if (!sel_s) begin
                    state_d = DLDU_ARMED;
                end else if (!hit_s) begin
                    state_d = DLDU_IDLE;
                end else if (dep_next_s != snap_q) begin
                    state_d = DLDU_ARMED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DLDU_REPORTED;
                end else begin
                    state_d = DLDU_ARMED;
                end
            end
            DLDU_REPORTED: begin
                if (token_clear || !blocked_s) begin
                    state_d = DLDU_IDLE;
                end else begin
                    state_d = DLDU_REPORTED;
                end
            end
            default: state_d = DLDU_IDLE;
        endcase
    end

    // Confirm FSM outputs: counter, snapshot, pulse and latched loop set.
    always_comb begin
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        pulse_d = 1'b0;
        procs_d = procs_q;
        case (state_q)
            DLDU_IDLE: begin
                if (hit_s) begin
                    snap_d = dep_next_s;
                    cnt_d  = CNT_ONE;
                    if (STABLE_CYCLES == 1) begin
                        pulse_d = 1'b1;
                        procs_d = dep_next_s | SELF_BIT;
                    end else begin
                        pulse_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DLDU_ARMED: begin
                if (!blocked_s) begin
                    cnt_d = '0;
                end else if (!sel_s) begin
                    cnt_d = cnt_q;
                end else if (!hit_s) begin
                    cnt_d = '0;
                end else if (dep_next_s != snap_q) begin
                    snap_d = dep_next_s;
                    cnt_d  = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        pulse_d = 1'b1;
                        procs_d = dep_next_s | SELF_BIT;
                    end else begin
                        pulse_d = 1'b0;
                    end
                end
            end
            DLDU_REPORTED: begin
                if (token_clear || !blocked_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Confirm FSM datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            snap_q  <= '0;
            pulse_q <= 1'b0;
            procs_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            pulse_q <= pulse_d;
            procs_q <= procs_d;
        end
    end

    // Dependence register and token forwarding.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg_q <= '0;
            token_q   <= '0;
        end else begin
            dep_reg_q <= blocked_s ? dep_next_s : '0;
            token_q   <= (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;
        end
    end

`ifdef DLDU_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    assign stall_cnt = stall_q;

    // Saturating count of consecutive blocked cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (!blocked_s) begin
            stall_q <= '0;
        end else if (&stall_q) begin
            stall_q <= stall_q;
        end else begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rocev2_top_hls_deadlock_confirm_unit.sv
// Directed bench for rocev2_top_hls_deadlock_confirm_unit (PROC_ID=1, STABLE_CYCLES=4).
module tb_rocev2_top_hls_deadlock_confirm_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] proc_dep_vld_vec;
    logic [1:0] in_chan_dep_vld_vec;
    logic [7:0] in_chan_dep_data_vec;
    logic [1:0] token_in_vec;
    logic       dl_detect_in;
    logic       origin;
    logic       token_clear;
    logic [2:0] out_chan_dep_vld_vec;
    logic [3:0] out_chan_dep_data;
    logic [2:0] token_out_vec;
    logic       dl_detect_out;
    logic [3:0] dl_cycle_procs;
    logic       dl_active;
`ifdef DLDU_STALL_CNT_EN
    logic [3:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic       det;
        logic       act;
        logic [3:0] procs;
        logic [3:0] dep;
        logic [2:0] tok;
        logic [2:0] vld;
    } exp_t;

    exp_t exp_q[$];

    rocev2_top_hls_deadlock_confirm_unit #(
        .PROC_NUM      (4),
        .PROC_ID       (1),
        .IN_CHAN_NUM   (2),
        .OUT_CHAN_NUM  (3),
        .STABLE_CYCLES (4),
        .STALL_CNT_W   (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .proc_dep_vld_vec     (proc_dep_vld_vec),
        .in_chan_dep_vld_vec  (in_chan_dep_vld_vec),
        .in_chan_dep_data_vec (in_chan_dep_data_vec),
        .token_in_vec         (token_in_vec),
        .dl_detect_in         (dl_detect_in),
        .origin               (origin),
        .token_clear          (token_clear),
        .out_chan_dep_vld_vec (out_chan_dep_vld_vec),
        .out_chan_dep_data    (out_chan_dep_data),
        .token_out_vec        (token_out_vec),
        .dl_detect_out        (dl_detect_out),
        .dl_cycle_procs       (dl_cycle_procs),
        .dl_active            (dl_active)
`ifdef DLDU_STALL_CNT_EN
        ,
        .stall_cnt            (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Push the expectation for the coming edge, clock once, then pop and compare.
    task automatic step(input string tag, input logic e_det, input logic e_act,
                        input logic [3:0] e_procs, input logic [3:0] e_dep,
                        input logic [2:0] e_tok);
        exp_t e;
        e.det   = e_det;
        e.act   = e_act;
        e.procs = e_procs;
        e.dep   = e_dep;
        e.tok   = e_tok;
        e.vld   = proc_dep_vld_vec;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_bit({tag, ".det"}, dl_detect_out, e.det);
        check_bit({tag, ".act"}, dl_active, e.act);
        check_vec({tag, ".procs"}, dl_cycle_procs, e.procs);
        check_vec({tag, ".dep"}, out_chan_dep_data, e.dep);
        check_vec({tag, ".tok"}, {1'b0, token_out_vec}, {1'b0, e.tok});
        check_vec({tag, ".vld"}, {1'b0, out_chan_dep_vld_vec}, {1'b0, e.vld});
    endtask

    initial begin
        reset                = 1'b0;
        proc_dep_vld_vec     = 3'b101;
        in_chan_dep_vld_vec  = 2'b00;
        in_chan_dep_data_vec = 8'h00;
        token_in_vec         = 2'b00;
        dl_detect_in         = 1'b0;
        origin               = 1'b0;
        token_clear          = 1'b0;

        // Reset: registered outputs cleared, dependence shows only own bit, vld passes through.
        exp_q.push_back('{det: 1'b0, act: 1'b0, procs: 4'b0000, dep: 4'b0010,
                          tok: 3'b000, vld: 3'b101});
        repeat (3) @(posedge clock);
        #1;
        begin
            exp_t e;
            e = exp_q.pop_front();
            check_bit("rst.det", dl_detect_out, e.det);
            check_bit("rst.act", dl_active, e.act);
            check_vec("rst.procs", dl_cycle_procs, e.procs);
            check_vec("rst.dep", out_chan_dep_data, e.dep);
            check_vec("rst.tok", {1'b0, token_out_vec}, {1'b0, e.tok});
            check_vec("rst.vld", {1'b0, out_chan_dep_vld_vec}, {1'b0, e.vld});
        end
        reset            = 1'b1;
        proc_dep_vld_vec = 3'b000;
        step("idle", 1'b0, 1'b0, 4'b0000, 4'b0010, 3'b000);

        // Persistent loop on ch0 (ch1 carries junk but is not valid).
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'h96;
        step("loop1", 1'b0, 1'b0, 4'b0000, 4'b0110, 3'b000);
        step("loop2", 1'b0, 1'b0, 4'b0000, 4'b0110, 3'b000);
        step("loop3", 1'b0, 1'b0, 4'b0000, 4'b0110, 3'b000);
        step("loop4", 1'b1, 1'b1, 4'b0110, 4'b0110, 3'b000);
        step("loop5", 1'b0, 1'b1, 4'b0110, 4'b0110, 3'b000);
        token_clear = 1'b1;
        step("clr",   1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        token_clear = 1'b0;
        step("fresh1", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("fresh2", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("fresh3", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("fresh4", 1'b1, 1'b1, 4'b0110, 4'b0110, 3'b000);
        proc_dep_vld_vec = 3'b000;
        step("unblk", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);

        // Transient: three hits, then unblocked; counting must start over.
        proc_dep_vld_vec = 3'b001;
        step("tr1", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("tr2", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("tr3", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        proc_dep_vld_vec = 3'b000;
        step("tr_drop", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);
        proc_dep_vld_vec = 3'b001;
        step("re1", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("re2", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("re3", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("re4", 1'b1, 1'b1, 4'b0110, 4'b0110, 3'b000);
        proc_dep_vld_vec = 3'b000;
        step("re_idle", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);

        // Changing dependence via both channels; pulse coincides with token_clear.
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b11;
        in_chan_dep_data_vec = 8'h06;
        step("chg1", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        step("chg2", 1'b0, 1'b0, 4'b0110, 4'b0110, 3'b000);
        in_chan_dep_data_vec = 8'h86;
        step("chg3", 1'b0, 1'b0, 4'b0110, 4'b1110, 3'b000);
        step("chg4", 1'b0, 1'b0, 4'b0110, 4'b1110, 3'b000);
        step("chg5", 1'b0, 1'b0, 4'b0110, 4'b1110, 3'b000);
        token_clear = 1'b1;
        step("chg6", 1'b1, 1'b1, 4'b1110, 4'b1110, 3'b000);
        token_clear = 1'b0;
        step("chg7", 1'b0, 1'b1, 4'b1110, 4'b1110, 3'b000);
        proc_dep_vld_vec = 3'b000;
        step("chg_idle", 1'b0, 1'b0, 4'b1110, 4'b0010, 3'b000);

        // Token gating: dl_detect_in without tokens freezes the counter and dep_reg.
        proc_dep_vld_vec     = 3'b001;
        in_chan_dep_vld_vec  = 2'b01;
        in_chan_dep_data_vec = 8'h06;
        step("tg1", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        step("tg2", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        dl_detect_in         = 1'b1;
        in_chan_dep_data_vec = 8'h08;
        step("hold1", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        step("hold2", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        step("hold3", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        dl_detect_in         = 1'b0;
        in_chan_dep_data_vec = 8'h06;
        step("rel1", 1'b0, 1'b0, 4'b1110, 4'b0110, 3'b000);
        step("rel2", 1'b1, 1'b1, 4'b0110, 4'b0110, 3'b000);
        proc_dep_vld_vec = 3'b000;
        step("rel_idle", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);

        // Token forwarding: origin, clear-suppressed and plain forwarding.
        in_chan_dep_vld_vec = 2'b00;
        proc_dep_vld_vec    = 3'b101;
        origin              = 1'b1;
        step("org", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b101);
        origin       = 1'b0;
        token_in_vec = 2'b01;
        token_clear  = 1'b1;
        step("tok_clr", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);
        token_clear = 1'b0;
        step("tok_fwd", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b101);
        token_in_vec = 2'b00;
        step("tok_none", 1'b0, 1'b0, 4'b0110, 4'b0010, 3'b000);

`ifdef DLDU_STALL_CNT_EN
        // Stall counter saturates at all-ones and drops to zero when unblocked.
        proc_dep_vld_vec = 3'b001;
        repeat (20) @(posedge clock);
        #1;
        check_vec("stall_sat", stall_cnt, 4'd15);
        proc_dep_vld_vec = 3'b000;
        @(posedge clock);
        #1;
        check_vec("stall_clr", stall_cnt, 4'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
